// File: rtl/pipe_add_pkg.sv
// Shared constants and the stage-count helper for the chunked pipelined adder.
package pipe_add_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 4;

  function automatic int stages_f(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/pipe_add_chunk.sv
// Combinational N-bit slice adder; also exposes the carry into its top bit
// so the final slice can flag signed overflow.
module add_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb_in
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

  if (N > 1) begin : g_wide
    logic [N-1:0] low;
    assign low      = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]} + {{(N-1){1'b0}}, ci};
    assign c_msb_in = low[N-1];
  end else begin : g_bit
    assign c_msb_in = ci;
  end
endmodule

// File: rtl/pipe_add.sv
// Ripple-carry adder/subtractor split into CHUNK-bit pipeline stages with
// operand skew and result deskew, behind a valid/ready handshake.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);
  localparam int STAGES = stages_f(WIDTH, CHUNK);

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~num2 : num2;
  assign c_eff    = sub ? ~cin : cin;

  // Stage k keeps finished result bits [DONE-1:0] plus the operand bits
  // not yet consumed; the whole pipe moves as one on advance.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO   = k * CHUNK;
    localparam int N    = (k == STAGES - 1) ? WIDTH - LO : CHUNK;
    localparam int DONE = LO + N;

    logic [N-1:0]    a_c, b_c, s_c;
    logic            ci_c, co_c, vld_in, vld, cy;
    logic [DONE-1:0] res_in, res;

    if (k == 0) begin : g_head
      assign a_c    = num1[N-1:0];
      assign b_c    = b_eff[N-1:0];
      assign ci_c   = c_eff;
      assign vld_in = in_valid;
      assign res_in = s_c;
    end else begin : g_body
      assign a_c    = g_stg[k-1].g_skew.a_rem[N-1:0];
      assign b_c    = g_stg[k-1].g_skew.b_rem[N-1:0];
      assign ci_c   = g_stg[k-1].cy;
      assign vld_in = g_stg[k-1].vld;
      assign res_in = {s_c, g_stg[k-1].res};
    end

    always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
        vld <= 1'b0;
        cy  <= 1'b0;
        res <= '0;
      end else if (advance) begin
        vld <= vld_in;
        cy  <= co_c;
        res <= res_in;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int REM = WIDTH - DONE;
      logic [REM-1:0] a_rem, b_rem, a_rem_in, b_rem_in;
      logic           msb_carry_unused;

      if (k == 0) begin : g_src_in
        assign a_rem_in = num1[WIDTH-1:DONE];
        assign b_rem_in = b_eff[WIDTH-1:DONE];
      end else begin : g_src_prev
        assign a_rem_in = g_stg[k-1].g_skew.a_rem[WIDTH-LO-1:N];
        assign b_rem_in = g_stg[k-1].g_skew.b_rem[WIDTH-LO-1:N];
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          a_rem <= a_rem_in;
          b_rem <= b_rem_in;
        end
      end

      add_chunk #(.N(N)) u_add (
        .a       (a_c),
        .b       (b_c),
        .ci      (ci_c),
        .s       (s_c),
        .co      (co_c),
        .c_msb_in(msb_carry_unused)
      );
    end else begin : g_tail
      logic c_msb, ovf;

      add_chunk #(.N(N)) u_add (
        .a       (a_c),
        .b       (b_c),
        .ci      (ci_c),
        .s       (s_c),
        .co      (co_c),
        .c_msb_in(c_msb)
      );

      always_ff @(posedge clk) begin
        if (!sync_reset_n) ovf <= 1'b0;
        else if (advance)  ovf <= co_c ^ c_msb;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld;
  assign sum       = {g_stg[STAGES-1].cy, g_stg[STAGES-1].res};
  assign overflow  = g_stg[STAGES-1].g_tail.ovf;
endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: 8/4 (two stages), 8/8 (single stage) and 13/4 (four
// stages, ragged last chunk), checked against an arithmetic reference.
module tb_pipe_add;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv, ir, sb, ci, ov, ordy, of;
  logic [7:0] n1, n2;
  logic [8:0] sm;
  logic       iv1, ir1, ov1, of1, ordy1;
  logic [8:0] sm1;
  logic        iv13, ir13, sb13, ci13, ov13, ordy13, of13;
  logic [12:0] a13, b13;
  logic [13:0] sm13;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_add #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clk(clk), .sync_reset_n(rst_n), .in_valid(iv), .in_ready(ir),
    .num1(n1), .num2(n2), .sub(sb), .cin(ci), .out_valid(ov),
    .out_ready(ordy), .sum(sm), .overflow(of));

  pipe_add #(.WIDTH(8), .CHUNK(8)) u_one (
    .clk(clk), .sync_reset_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .num1(n1), .num2(n2), .sub(sb), .cin(ci), .out_valid(ov1),
    .out_ready(ordy1), .sum(sm1), .overflow(of1));

  pipe_add #(.WIDTH(13), .CHUNK(4)) u_w13 (
    .clk(clk), .sync_reset_n(rst_n), .in_valid(iv13), .in_ready(ir13),
    .num1(a13), .num2(b13), .sub(sb13), .cin(ci13), .out_valid(ov13),
    .out_ready(ordy13), .sum(sm13), .overflow(of13));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: true integer arithmetic, overflow = signed result out of range.
  function automatic void ref_calc(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit s, input bit c,
                                   output longint unsigned rs, output bit ro);
    longint unsigned full = 64'd1 << w;
    longint sa, sbv, t;
    if (s) rs = (a + full - b - c) % (full * 2);
    else   rs = (a + b + c) % (full * 2);
    sa  = (a >= full / 2) ? longint'(a) - longint'(full) : longint'(a);
    sbv = (b >= full / 2) ? longint'(b) - longint'(full) : longint'(b);
    t   = s ? sa - sbv - longint'(c) : sa + sbv + longint'(c);
    ro  = (t < -longint'(full / 2)) || (t >= longint'(full / 2));
  endfunction

  typedef struct packed {logic [8:0] s; logic o;} exp_t;
  exp_t q8[$];
  bit held8 = 0;
  longint unsigned m_sum;
  bit m_ovf;

  // Scoreboard for the 8/4 instance: every visible result must match the
  // oldest outstanding operation; reset discards everything in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
      held8 = 0;
    end else begin
      if (held8) check("hold_valid", ov, 1);
      if (ov) begin
        if (q8.size() == 0) check("spurious_valid", ov, 0);
        else begin
          check("sb_sum", sm, q8[0].s);
          check("sb_ovf", of, q8[0].o);
          if (ordy) void'(q8.pop_front());
        end
      end
      if (iv && ir) begin
        ref_calc(8, n1, n2, sb, ci, m_sum, m_ovf);
        q8.push_back('{s: m_sum[8:0], o: m_ovf});
      end
      held8 = ov && !ordy;
    end
  end

  typedef struct {logic [7:0] a, b; logic s, c; logic [8:0] e_sum; logic e_ovf;} vec_t;
  vec_t tab[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, got, stall, acc, cyc, n13;
    bit seen;
    logic [7:0] st_a[4];
    logic [7:0] st_b[4];
    longint unsigned q13s[$];
    bit q13o[$];
    longint unsigned r13;
    bit o13;

    tab[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0};
    tab[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1};
    tab[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 9'h0FE, 1'b0};
    tab[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1};
    tab[4] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 9'h1FF, 1'b0};
    tab[5] = '{8'h00, 8'h01, 1'b1, 1'b0, 9'h0FF, 1'b0};
    tab[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 9'h17F, 1'b1};
    tab[7] = '{8'h3C, 8'h0F, 1'b1, 1'b1, 9'h12C, 1'b0};
    tab[8] = '{8'h12, 8'h34, 1'b0, 1'b1, 9'h047, 1'b0};

    rst_n = 0; iv = 0; iv1 = 0; iv13 = 0; n1 = 0; n2 = 0; sb = 0; ci = 0;
    ordy = 1; ordy1 = 1; ordy13 = 1; a13 = 0; b13 = 0; sb13 = 0; ci13 = 0;
    repeat (3) step();
    check("reset_ready", ir, 1);
    check("reset_valid", ov, 0);
    check("reset_sum", sm, 0);
    check("reset_ovf", of, 0);
    check("reset_valid_one", ov1, 0);
    check("reset_valid_w13", ov13, 0);
    rst_n = 1;

    // Directed vectors; the first is presented in the first cycle out of reset.
    for (int v = 0; v < 9; v++) begin
      n1 = tab[v].a; n2 = tab[v].b; sb = tab[v].s; ci = tab[v].c;
      iv = 1; iv1 = 1;
      check($sformatf("v%0d_ready", v), ir, 1);
      check($sformatf("v%0d_ready_one", v), ir1, 1);
      step();
      iv = 0; iv1 = 0;
      check($sformatf("v%0d_lat1_valid", v), ov, 0);
      check($sformatf("v%0d_one_valid", v), ov1, 1);
      check($sformatf("v%0d_one_sum", v), sm1, tab[v].e_sum);
      check($sformatf("v%0d_one_ovf", v), of1, tab[v].e_ovf);
      step();
      check($sformatf("v%0d_valid", v), ov, 1);
      check($sformatf("v%0d_sum", v), sm, tab[v].e_sum);
      check($sformatf("v%0d_ovf", v), of, tab[v].e_ovf);
      check($sformatf("v%0d_one_bubble", v), ov1, 0);
    end
    step(); step();

    // Reset one cycle after an accept: that operation must vanish.
    n1 = 8'h10; n2 = 8'h20; sb = 0; ci = 0; iv = 1;
    step();
    iv = 0; rst_n = 0;
    step();
    check("rst_ready_during", ir, 1);
    rst_n = 1;
    check("rst_ready_after", ir, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rst_flush_valid%0d", k), ov, 0);
    end

    // Four back-to-back operations, consumer stalls 3 cycles after the first result.
    st_a = '{8'h11, 8'h9A, 8'h7F, 8'hC3};
    st_b = '{8'h22, 8'h0B, 8'h7F, 8'h3D};
    i = 0; got = 0; stall = 0; seen = 0;
    for (int c2 = 0; c2 < 20 && got < 4; c2++) begin
      iv = (i < 4);
      if (i < 4) begin n1 = st_a[i]; n2 = st_b[i]; end
      sb = 0; ci = 0;
      ordy = (stall == 0);
      @(negedge clk);
      if (stall > 0) begin
        check("stall_ready", ir, 0);
        check("stall_valid", ov, 1);
        stall--;
      end
      if (iv && ir) i++;
      if (ov && ordy) begin
        got++;
        if (!seen) begin seen = 1; stall = 3; end
      end
      @(posedge clk); #1;
    end
    iv = 0; ordy = 1;
    check("stall_results", got, 4);
    check("stall_accepts", i, 4);
    step(); step();

    // Random traffic with random bubbles and back-pressure.
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      n1 = 8'($urandom); n2 = 8'($urandom);
      sb = 1'($urandom); ci = 1'($urandom);
      @(negedge clk);
      if (iv && ir) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_accepts", acc, 10000);
    iv = 0; ordy = 1;
    repeat (6) step();
    check("rand_drained", q8.size(), 0);

    // 13-bit, four stages, last chunk one bit wide: -4096 - 1 - 1 wraps.
    a13 = 13'h1000; b13 = 13'h0001; sb13 = 1; ci13 = 1; iv13 = 1;
    step();
    iv13 = 0;
    for (int k = 1; k < 4; k++) begin
      check($sformatf("w13_lat%0d_valid", k), ov13, 0);
      step();
    end
    check("w13_valid", ov13, 1);
    check("w13_sum", sm13, 14'h2FFE);
    check("w13_carry", sm13[13], 1);
    check("w13_ovf", of13, 1);
    step();

    // 13-bit streaming at full rate.
    n13 = 0;
    for (int c3 = 0; c3 < 220; c3++) begin
      iv13 = (c3 < 200);
      a13 = 13'($urandom); b13 = 13'($urandom);
      sb13 = 1'($urandom); ci13 = 1'($urandom);
      @(negedge clk);
      if (ov13) begin
        if (q13s.size() == 0) check("w13_spurious", ov13, 0);
        else begin
          check("w13_rsum", sm13, q13s.pop_front());
          check("w13_rovf", of13, q13o.pop_front());
          n13++;
        end
      end
      if (iv13) check("w13_full_rate_ready", ir13, 1);
      if (iv13 && ir13) begin
        ref_calc(13, a13, b13, sb13, ci13, r13, o13);
        q13s.push_back(r13);
        q13o.push_back(o13);
      end
      @(posedge clk); #1;
    end
    check("w13_results", n13, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
